// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top -- Game Boy LCD pixel capture into a 160x144 2-bit frame buffer.
//
// The LCD pixel strobe (PX_CLK) clocks everything. Every rising edge samples
// the two shade bits and the line/frame syncs. While both syncs are low the
// sampled shade is written at PIX_Y*160+PIX_X and the write position
// advances in raster order. A separate read port returns buffer contents
// one cycle after the address is presented.
//
// Ports
//   PX_CLK       in   pixel strobe, sole clock (rising edge)
//   RESET_N      in   asynchronous active-low reset
//   CLK_3P3_MHZ  in   reserved display-side clock, unused
//   D0, D1       in   pixel shade bits (D1 = MSB)
//   HSYNC        in   line sync, active high
//   VSYNC        in   frame sync, active high
//   RD_ADDR[14:0] in  frame-buffer read address (y*160+x)
//   RD_DATA[1:0] out  registered read data, 0 for addresses past the buffer
//   PIX_X[7:0]   out  current write column 0..159
//   PIX_Y[7:0]   out  current write row 0..143
//   FRAME_DONE   out  one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module top (
    input  logic        PX_CLK,
    input  logic        RESET_N,
    input  logic        CLK_3P3_MHZ,
    input  logic        D0,
    input  logic        D1,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [14:0] RD_ADDR,
    output logic [1:0]  RD_DATA,
    output logic [7:0]  PIX_X,
    output logic [7:0]  PIX_Y,
    output logic        FRAME_DONE
);

    localparam logic [14:0] FB_WORDS = 15'd23040;
    localparam logic [14:0] LINE_LEN = 15'd160;
    localparam logic [7:0]  LAST_X   = 8'd159;
    localparam logic [7:0]  LAST_Y   = 8'd143;

    logic [1:0]  mem_r [0:23039];
    logic [7:0]  pix_x_r;
    logic [7:0]  pix_y_r;
    logic        hsync_prev_r;
    logic        frame_done_r;
    logic [1:0]  rd_data_r;

    logic [7:0]  pix_x_nxt_s;
    logic [7:0]  pix_y_nxt_s;
    logic        frame_done_nxt_s;
    logic        wr_en_s;
    logic [14:0] wr_addr_s;

    // The display-side clock is intentionally left unconnected for now.
    logic        unused_s;
    assign unused_s = CLK_3P3_MHZ;

    // Write address from the current counters; max 143*160+159 fits 15 bits.
    assign wr_addr_s = ({7'd0, pix_y_r} * LINE_LEN) + {7'd0, pix_x_r};

    // Next-state for the raster counters: VSYNC beats HSYNC beats pixel write.
    always_comb begin
        pix_x_nxt_s      = pix_x_r;
        pix_y_nxt_s      = pix_y_r;
        frame_done_nxt_s = 1'b0;
        wr_en_s          = 1'b0;
        if (VSYNC) begin
            pix_x_nxt_s = 8'd0;
            pix_y_nxt_s = 8'd0;
        end else if (HSYNC) begin
            // Only the first edge of an HSYNC pulse ends a line, and only if
            // the line actually has pixels; otherwise counters hold.
            if (!hsync_prev_r && (pix_x_r != 8'd0)) begin
                pix_x_nxt_s = 8'd0;
                if (pix_y_r >= LAST_Y) begin
                    pix_y_nxt_s = 8'd0;
                end else begin
                    pix_y_nxt_s = pix_y_r + 8'd1;
                end
            end else begin
                pix_x_nxt_s = pix_x_r;
                pix_y_nxt_s = pix_y_r;
            end
        end else begin
            wr_en_s = 1'b1;
            // >= rather than == so a corrupted counter folds back in range.
            if (pix_x_r >= LAST_X) begin
                pix_x_nxt_s = 8'd0;
                if (pix_y_r >= LAST_Y) begin
                    pix_y_nxt_s      = 8'd0;
                    frame_done_nxt_s = 1'b1;
                end else begin
                    pix_y_nxt_s = pix_y_r + 8'd1;
                end
            end else begin
                pix_x_nxt_s = pix_x_r + 8'd1;
            end
        end
    end

    // Raster counters, HSYNC history and frame-done pulse.
    always_ff @(posedge PX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_x_r      <= 8'd0;
            pix_y_r      <= 8'd0;
            hsync_prev_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            pix_x_r      <= pix_x_nxt_s;
            pix_y_r      <= pix_y_nxt_s;
            hsync_prev_r <= HSYNC;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Frame-buffer write port; contents survive reset, writes blocked in reset.
    always_ff @(posedge PX_CLK) begin
        if (wr_en_s && RESET_N) begin
            mem_r[wr_addr_s] <= {D1, D0};
        end
    end

    // Registered read port; returns pre-write data on a same-address collision.
    always_ff @(posedge PX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_data_r <= 2'b00;
        end else if (RD_ADDR < FB_WORDS) begin
            rd_data_r <= mem_r[RD_ADDR];
        end else begin
            rd_data_r <= 2'b00;
        end
    end

    assign RD_DATA    = rd_data_r;
    assign PIX_X      = pix_x_r;
    assign PIX_Y      = pix_y_r;
    assign FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top -- self-checking bench for the LCD capture frame buffer.
// Stimulus pushes expected read data into a queue; a negedge monitor pops and
// compares whenever a read result is due, and also compares the raster
// counters and FRAME_DONE against a small behavioural reference each cycle.
// -----------------------------------------------------------------------------
module tb_top;

    logic        PX_CLK      = 1'b0;
    logic        CLK_3P3_MHZ = 1'b0;
    logic        RESET_N;
    logic        D0;
    logic        D1;
    logic        HSYNC;
    logic        VSYNC;
    logic [14:0] RD_ADDR;
    logic [1:0]  RD_DATA;
    logic [7:0]  PIX_X;
    logic [7:0]  PIX_Y;
    logic        FRAME_DONE;

    top dut (
        .PX_CLK      (PX_CLK),
        .RESET_N     (RESET_N),
        .CLK_3P3_MHZ (CLK_3P3_MHZ),
        .D0          (D0),
        .D1          (D1),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .RD_ADDR     (RD_ADDR),
        .RD_DATA     (RD_DATA),
        .PIX_X       (PIX_X),
        .PIX_Y       (PIX_Y),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 PX_CLK = ~PX_CLK;
    always #151 CLK_3P3_MHZ = ~CLK_3P3_MHZ;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [1:0] exp_q [$];
    logic       rd_req   = 1'b0;
    logic       rd_vld_d = 1'b0;
    logic       mon_en   = 1'b0;
    int         fd_count = 0;

    // reference model state
    int         mx = 0;
    int         my = 0;
    logic       mprev = 1'b0;
    logic       efd = 1'b0;
    logic [1:0] mmem [23040];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // one clock edge, then advance the reference using the held inputs
    task automatic tick();
        @(posedge PX_CLK);
        #1;
        if (!RESET_N) begin
            mx = 0; my = 0; mprev = 1'b0; efd = 1'b0;
        end else begin
            efd = 1'b0;
            if (VSYNC) begin
                mx = 0; my = 0;
            end else if (HSYNC) begin
                if (!mprev && mx != 0) begin
                    mx = 0;
                    my = (my == 143) ? 0 : my + 1;
                end
            end else begin
                mmem[my * 160 + mx] = {D1, D0};
                if (mx == 159) begin
                    mx = 0;
                    if (my == 143) begin my = 0; efd = 1'b1; end
                    else my = my + 1;
                end else mx = mx + 1;
            end
            mprev = HSYNC;
        end
    endtask

    task automatic pix(input logic [1:0] d);
        {D1, D0} = d; HSYNC = 1'b0; VSYNC = 1'b0;
        tick();
    endtask

    task automatic pix_rd(input logic [1:0] d, input int addr, input logic [1:0] e);
        RD_ADDR = 15'(addr); rd_req = 1'b1; exp_q.push_back(e);
        pix(d);
        rd_req = 1'b0;
    endtask

    task automatic idle_rd(input int addr, input logic [1:0] e);
        RD_ADDR = 15'(addr); rd_req = 1'b1; exp_q.push_back(e);
        HSYNC = 1'b1; VSYNC = 1'b0;
        tick();
        rd_req = 1'b0;
    endtask

    always @(posedge PX_CLK) rd_vld_d <= rd_req;

    // monitor: read scoreboard plus per-cycle counter / frame-done comparison
    always @(negedge PX_CLK) begin
        if (mon_en) begin
            chk("pix_x", int'(PIX_X), mx);
            chk("pix_y", int'(PIX_Y), my);
            chk("frame_done", int'(FRAME_DONE), int'(efd));
            if (FRAME_DONE) fd_count++;
            if (rd_vld_d) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", int'(RD_DATA), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int fd_base;
        RESET_N = 1'b0; {D1, D0} = 2'b00; HSYNC = 1'b0; VSYNC = 1'b0; RD_ADDR = 15'd0;
        repeat (3) tick();
        RESET_N = 1'b1;
        chk("reset_x", int'(PIX_X), 0);
        chk("reset_y", int'(PIX_Y), 0);
        chk("reset_fd", int'(FRAME_DONE), 0);
        chk("reset_rd", int'(RD_DATA), 0);
        mon_en = 1'b1;

        // four shades to addresses 0..3, read back while writing 4..7 with 3
        pix(2'd0); pix(2'd1); pix(2'd2); pix(2'd3);
        chk("x_after4", int'(PIX_X), 4);
        chk("y_after4", int'(PIX_Y), 0);
        pix_rd(2'd3, 0, 2'd0); pix_rd(2'd3, 1, 2'd1);
        pix_rd(2'd3, 2, 2'd2); pix_rd(2'd3, 3, 2'd3);

        // HSYNC high for three edges after 10 pixels: one line increment
        pix(2'd1); pix(2'd1);
        chk("x_before_hs", int'(PIX_X), 10);
        HSYNC = 1'b1; VSYNC = 1'b0;
        repeat (3) tick();
        chk("hs_x", int'(PIX_X), 0);
        chk("hs_y", int'(PIX_Y), 1);
        pix(2'd2);
        pix_rd(2'd0, 160, 2'd2);

        // mid-frame VSYNC for two edges with shade 3 driven: nothing written
        {D1, D0} = 2'd3; HSYNC = 1'b0; VSYNC = 1'b1;
        repeat (2) tick();
        chk("vs_x", int'(PIX_X), 0);
        chk("vs_y", int'(PIX_Y), 0);
        idle_rd(0, 2'd0); idle_rd(1, 2'd1);
        pix(2'd2);
        pix_rd(2'd0, 0, 2'd2);

        // same-edge write and read of address 5 (old value 3, new value 2)
        pix(2'd0); pix(2'd0); pix(2'd0);
        chk("x_at5", int'(PIX_X), 5);
        pix_rd(2'd2, 5, 2'd3);
        pix_rd(2'd0, 5, 2'd2);
        pix(2'd1);

        // asynchronous reset between edges mid-line
        #2;
        RESET_N = 1'b0;
        mx = 0; my = 0; mprev = 1'b0; efd = 1'b0;
        #1;
        chk("arst_x", int'(PIX_X), 0);
        chk("arst_y", int'(PIX_Y), 0);
        chk("arst_fd", int'(FRAME_DONE), 0);
        chk("arst_rd", int'(RD_DATA), 0);
        {D1, D0} = 2'd3; HSYNC = 1'b0; VSYNC = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
        idle_rd(7, 2'd1); idle_rd(0, 2'd2); idle_rd(160, 2'd2);
        pix(2'd1);
        pix_rd(2'd0, 0, 2'd1);

        // reads past the end of the buffer return 0
        HSYNC = 1'b0; VSYNC = 1'b1;
        tick();
        idle_rd(23040, 2'd0); idle_rd(32767, 2'd0);

        // two full frames of free-running capture
        fd_base = fd_count;
        for (int i = 0; i < 46080; i++) pix(2'($urandom_range(0, 2)));
        HSYNC = 1'b1; VSYNC = 1'b0;
        tick();
        chk("frames_fd_count", fd_count - fd_base, 2);
        chk("frames_x", int'(PIX_X), 0);
        chk("frames_y", int'(PIX_Y), 0);
        for (int a = 0; a < 23040; a++) idle_rd(a, mmem[a]);

        HSYNC = 1'b1; VSYNC = 1'b0;
        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
